// File: rtl/lsu.sv
// Load/store unit: byte-addressed byte/half/word requests onto a word-wide memory port,
// with read-modify-write for sub-word stores. Optional macro: LSU_MISALIGN_FAULT_EN.
module lsu #(
    parameter int MEM_SIZE = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READ,
        WRITE,
        RESP
    } state_t;

    localparam logic [29:0] MEM_WORDS = 30'(MEM_SIZE);

    state_t      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_fault_q, rsp_fault_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [31:0] mem_wd_q, mem_wd_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [15:0] wdata_q, wdata_d;

    logic        misalign;
    logic        fault;

`ifdef LSU_MISALIGN_FAULT_EN
    assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign fault = (req_size == 2'b11) || (req_addr[31:2] >= MEM_WORDS) || misalign;

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                            input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] result;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   result = uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   result = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: result = word;
        endcase
        return result;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] lane, input logic [15:0] wd);
        logic [31:0] result;
        result = word;
        if (size == 2'b00) begin
            case (lane)
                2'd0:    result[7:0]   = wd[7:0];
                2'd1:    result[15:8]  = wd[7:0];
                2'd2:    result[23:16] = wd[7:0];
                default: result[31:24] = wd[7:0];
            endcase
        end else if (lane[1]) begin
            result[31:16] = wd;
        end else begin
            result[15:0] = wd;
        end
        return result;
    endfunction

    // Response and write strobes default low so they pulse for exactly one state.
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_fault_d = 1'b0;
        rsp_rdata_d = 32'h0;
        mem_we_d    = 1'b0;
        mem_a_d     = mem_a_q;
        mem_wd_d    = 32'h0;
        lane_d      = lane_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        wdata_d     = wdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    lane_d      = req_addr[1:0];
                    size_d      = req_size;
                    unsigned_d  = req_unsigned;
                    wdata_d     = req_wdata[15:0];
                    req_ready_d = 1'b0;
                    if (fault) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_fault_d = 1'b1;
                    end else if (!req_we) begin
                        state_d = LOAD;
                        mem_a_d = {2'b00, req_addr[31:2]};
                    end else if (req_size == 2'b10) begin
                        state_d  = WRITE;
                        mem_we_d = 1'b1;
                        mem_a_d  = {2'b00, req_addr[31:2]};
                        mem_wd_d = req_wdata;
                    end else begin
                        state_d = READ;
                        mem_a_d = {2'b00, req_addr[31:2]};
                    end
                end
            end
            LOAD: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = extract(mem_rd, size_q, lane_q, unsigned_q);
                mem_a_d     = 32'h0;
            end
            READ: begin
                // mem_a is held into WRITE so the merge lands on the word just read.
                state_d  = WRITE;
                mem_we_d = 1'b1;
                mem_wd_d = merge(mem_rd, size_q, lane_q, wdata_q);
            end
            WRITE: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                mem_a_d     = 32'h0;
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                mem_a_d     = 32'h0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            mem_we_q    <= 1'b0;
            mem_a_q     <= 32'h0;
            mem_wd_q    <= 32'h0;
            lane_q      <= 2'b00;
            size_q      <= 2'b00;
            unsigned_q  <= 1'b0;
            wdata_q     <= 16'h0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_fault_q <= rsp_fault_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_we_q    <= mem_we_d;
            mem_a_q     <= mem_a_d;
            mem_wd_q    <= mem_wd_d;
            lane_q      <= lane_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            wdata_q     <= wdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_fault = rsp_fault_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_we    = mem_we_q;
    assign mem_a     = mem_a_q;
    assign mem_wd    = mem_wd_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: a byte-level reference model predicts each response, a scoreboard
// queue carries it to an independent monitor, and final memory contents are compared.
module tb_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int we_count = 0;

    logic [31:0] mem      [64];
    logic [31:0] init_mem [64];
    logic [31:0] ref_mem  [64];
    logic        load_init = 1'b0;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          cycle;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    lsu #(.MEM_SIZE(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_fault    (rsp_fault),
        .mem_we       (mem_we),
        .mem_a        (mem_a),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd)
    );

    // Attached data memory: combinational read, write on the rising edge.
    assign mem_rd = (mem_a < 32'd64) ? mem[mem_a[5:0]] : 32'h0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_mem[i];
        end else if (mem_we) begin
            mem[mem_a[5:0]] <= mem_wd;
            we_count <= we_count + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model computed from the lane rules with plain arithmetic.
    function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] rdata, output logic flt, output int lat);
        int unsigned idx;
        int unsigned lane;
        logic [31:0] w;
        logic [31:0] v;
        logic        mis;
        idx  = int'(addr >> 2);
        lane = int'(addr & 32'h3);
        mis  = 1'b0;
`ifdef LSU_MISALIGN_FAULT_EN
        mis = (size == 2'd1 && (addr % 2) != 0) || (size == 2'd2 && (addr % 4) != 0);
`endif
        flt   = (size == 2'd3) || (idx >= 64) || mis;
        rdata = 32'h0;
        if (flt) begin
            lat = 1;
        end else if (!we) begin
            w = ref_mem[idx];
            lat = 2;
            if (size == 2'd0) begin
                v = (w >> (8 * lane)) & 32'hFF;
                if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
            end else if (size == 2'd1) begin
                v = (w >> (16 * (lane / 2))) & 32'hFFFF;
                if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
            end else begin
                v = w;
            end
            rdata = v;
        end else if (size == 2'd2) begin
            ref_mem[idx] = wdata;
            lat = 2;
        end else begin
            w = ref_mem[idx];
            if (size == 2'd0) w[8*lane +: 8] = wdata[7:0];
            else              w[16*(lane/2) +: 16] = wdata[15:0];
            ref_mem[idx] = w;
            lat = 3;
        end
    endfunction

    // Called at a falling edge; returns at the falling edge of the cycle after acceptance.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input bit expect_rsp);
        int t;
        exp_t e;
        int lat;
        t = 0;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout actual=0 expected=1");
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        if (expect_rsp) begin
            model(we, size, uns, addr, wdata, e.rdata, e.fault, lat);
            e.cycle = cyc + lat;
            exp_q.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout actual=%0d expected=0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: pops the scoreboard whenever a response appears and polices idle port values.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (req_ready) begin
                checkOutput("idle_mem_we", {31'h0, mem_we}, 32'h0);
                checkOutput("idle_mem_a", mem_a, 32'h0);
                checkOutput("idle_mem_wd", mem_wd, 32'h0);
            end
            if (mem_we) checkOutput("we_in_range", {31'h0, mem_a < 32'd64}, 32'h1);
            if (rsp_valid) begin
                checkOutput("rsp_ready_low", {31'h0, req_ready}, 32'h0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_rsp actual=1 expected=0");
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("rsp_rdata", rsp_rdata, e.rdata);
                    checkOutput("rsp_fault", {31'h0, rsp_fault}, {31'h0, e.fault});
                    checkOutput("rsp_cycle", 32'(cyc), 32'(e.cycle));
                end
            end
        end
    end

    initial begin
        int snap;
        int r;
        logic [1:0] sz;
        logic [31:0] a;

        reset        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        for (int i = 0; i < 64; i++) init_mem[i] = $urandom;
        init_mem[4] = 32'h11223344;
        init_mem[5] = 32'h0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_mem[i];
        load_init = 1'b1;
        repeat (2) @(negedge clk);
        load_init = 1'b0;

        checkOutput("reset_ready", {31'h0, req_ready}, 32'h1);
        checkOutput("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        checkOutput("reset_rsp_fault", {31'h0, rsp_fault}, 32'h0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset_mem_we", {31'h0, mem_we}, 32'h0);
        checkOutput("reset_mem_a", mem_a, 32'h0);
        checkOutput("reset_mem_wd", mem_wd, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        applyStimulus(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 1'b1);
        drain();

        applyStimulus(1'b1, 2'd0, 1'b0, 32'h13, 32'hA5, 1'b1);
        checkOutput("bs_read_we", {31'h0, mem_we}, 32'h0);
        checkOutput("bs_read_a", mem_a, 32'h4);
        drain();
        checkOutput("bs_word", mem[4], 32'hA5223344);
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b1);
        applyStimulus(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b1);
        drain();

        applyStimulus(1'b1, 2'd1, 1'b0, 32'h16, 32'h8001, 1'b1);
        drain();
        checkOutput("hs_word", mem[5], 32'h80010000);
        applyStimulus(1'b0, 2'd1, 1'b0, 32'h16, 32'h0, 1'b1);
        applyStimulus(1'b0, 2'd1, 1'b0, 32'h14, 32'h0, 1'b1);
        drain();

        applyStimulus(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1);
        checkOutput("ws_we", {31'h0, mem_we}, 32'h1);
        checkOutput("ws_a", mem_a, 32'h4);
        checkOutput("ws_wd", mem_wd, 32'hDEADBEEF);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
        drain();
        checkOutput("ws_word", mem[4], 32'hDEADBEEF);

        snap = we_count;
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h100, 32'h12345678, 1'b1);
        applyStimulus(1'b1, 2'd3, 1'b0, 32'h8, 32'h12345678, 1'b1);
        applyStimulus(1'b0, 2'd3, 1'b0, 32'h8, 32'h0, 1'b1);
        drain();
        checkOutput("fault_no_we", 32'(we_count - snap), 32'h0);

        // Reset asserted while the byte store sits in its read phase.
        snap = we_count;
        applyStimulus(1'b1, 2'd0, 1'b0, 32'h20, 32'h5A, 1'b0);
        reset = 1'b0;
        #1;
        checkOutput("rst_mem_we_now", {31'h0, mem_we}, 32'h0);
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", {31'h0, req_ready}, 32'h1);
        checkOutput("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        checkOutput("rst_mem_a", mem_a, 32'h0);
        checkOutput("rst_mem_wd", mem_wd, 32'h0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready_after", {31'h0, req_ready}, 32'h1);
        checkOutput("rst_no_we", 32'(we_count - snap), 32'h0);
        checkOutput("rst_word_kept", mem[8], ref_mem[8]);

        for (int n = 0; n < 300; n++) begin
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            a  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(256, 300))
                                             : 32'($urandom_range(0, 255));
            applyStimulus(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        for (int i = 0; i < 64; i++) checkOutput("final_mem", mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
